// File: rtl/tmr_sched_pkg.sv
// Shared constants and helpers for the multi-channel alarm scheduler.
package tmr_sched_pkg;

   localparam int CW_DEF  = 32;
   localparam int NCH_MAX = 16;

   // Width of a channel index; a single bit is kept even for N <= 2.
   function automatic int ch_idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // LSB position of channel ch inside a flat NCH*CW delay bus.
   function automatic int dly_lsb(input int ch, input int cw);
      return ch * cw;
   endfunction

endpackage

// File: rtl/tmr_alarm_sched_rr_arbiter.sv
// Round-robin one-hot arbiter: grants the first request at/after the pointer,
// pointer moves past the granted index and holds when nothing is granted.
module rr_arbiter
   import tmr_sched_pkg::*;
#(
   parameter int N = 4
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] i_req,
   output logic [N-1:0] o_grant
);

   localparam int IW = ch_idx_w(N);

   logic [IW-1:0] r_ptr;
   logic [IW-1:0] w_idx;
   logic [IW-1:0] w_gidx;
   logic          w_any;

   // Scan offsets from farthest to nearest so the nearest hit is the one kept.
   always_comb begin
      o_grant = '0;
      w_gidx  = '0;
      w_any   = 1'b0;
      w_idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_idx = (int'(r_ptr) + k >= N) ? IW'(int'(r_ptr) + k - N) : IW'(int'(r_ptr) + k);
         if (i_req[w_idx]) begin
            o_grant        = '0;
            o_grant[w_idx] = 1'b1;
            w_gidx         = w_idx;
            w_any          = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (w_any) begin
         r_ptr <= (w_gidx == IW'(N - 1)) ? '0 : w_gidx + IW'(1);
      end
   end

endmodule

// File: rtl/tmr_alarm_sched.sv
// Multi-channel one-shot alarm scheduler on a shared prescaled timebase.
// Define TMR_SCHED_PERIODIC_EN to add auto-reloading periodic channels.
module tmr_alarm_sched
   import tmr_sched_pkg::*;
#(
   parameter int NCH = 4,
   parameter int CW  = CW_DEF
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [CW-1:0]     pre,
   output logic [CW-1:0]     now,
   input  logic [NCH-1:0]    req,
   input  logic [NCH*CW-1:0] req_delay,
   output logic [NCH-1:0]    ack,
   input  logic [NCH-1:0]    cancel,
   output logic [NCH-1:0]    busy,
   output logic [NCH-1:0]    fire,
   input  logic [NCH-1:0]    irq_clr,
   output logic [NCH-1:0]    pending,
   output logic              irq
`ifdef TMR_SCHED_PERIODIC_EN
   ,
   input  logic [NCH-1:0]    req_periodic
`endif
);

   logic [CW-1:0]  r_divcnt;
   logic [CW-1:0]  r_now;
   logic           w_tick;
   logic [NCH-1:0] w_busy;
   logic [NCH-1:0] w_fire;
   logic [NCH-1:0] w_pending;
   logic [NCH-1:0] w_grant;

   // >= rather than == so lowering pre mid-count ticks at once.
   assign w_tick = en & (r_divcnt >= pre);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_divcnt <= '0;
         r_now    <= '0;
      end else if (w_tick) begin
         r_divcnt <= '0;
         r_now    <= r_now + CW'(1);
      end else if (en) begin
         r_divcnt <= r_divcnt + CW'(1);
      end
   end

   rr_arbiter #(.N(NCH)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_req   (req & ~w_busy),
      .o_grant (w_grant)
   );

   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [CW-1:0] r_rem;
      logic          r_busy;
      logic          r_fire;
      logic          r_pending;
      logic [CW-1:0] w_dly_raw;
      logic [CW-1:0] w_dly;
      logic          w_expire;

      assign w_dly_raw = req_delay[dly_lsb(gi, CW) +: CW];
      assign w_dly     = (w_dly_raw == '0) ? CW'(1) : w_dly_raw;
      // A same-cycle cancel suppresses the expiry entirely.
      assign w_expire  = w_tick & r_busy & (r_rem == CW'(1)) & ~cancel[gi];

`ifdef TMR_SCHED_PERIODIC_EN
      logic          r_per;
      logic [CW-1:0] r_reload;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_per    <= 1'b0;
            r_reload <= '0;
         end else if (w_grant[gi]) begin
            r_per    <= req_periodic[gi];
            r_reload <= w_dly;
         end
      end
`endif

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_rem     <= '0;
            r_busy    <= 1'b0;
            r_fire    <= 1'b0;
            r_pending <= 1'b0;
         end else begin
            r_fire    <= w_expire;
            r_pending <= w_expire | (r_pending & ~irq_clr[gi]);
            if (w_grant[gi]) begin
               r_rem  <= w_dly;
               r_busy <= 1'b1;
            end else if (r_busy & cancel[gi]) begin
               r_busy <= 1'b0;
            end else if (w_expire) begin
`ifdef TMR_SCHED_PERIODIC_EN
               if (r_per) r_rem <= r_reload;
               else       r_busy <= 1'b0;
`else
               r_busy <= 1'b0;
`endif
            end else if (w_tick & r_busy) begin
               r_rem <= r_rem - CW'(1);
            end
         end
      end

      assign w_busy[gi]    = r_busy;
      assign w_fire[gi]    = r_fire;
      assign w_pending[gi] = r_pending;
   end

   assign now     = r_now;
   assign ack     = w_grant;
   assign busy    = w_busy;
   assign fire    = w_fire;
   assign pending = w_pending;
   assign irq     = |w_pending;

endmodule

// File: tb/tb_tmr_alarm_sched.sv
// Scoreboard bench for tmr_alarm_sched: a tick-level reference model queues the
// expected status and ack/fire events; a negedge monitor pops and compares them.
module tb_tmr_alarm_sched;

   localparam int NCH  = 4;
   localparam int CW   = 10;
   localparam int MAXV = (1 << CW) - 1;

   logic              clk       = 1'b0;
   logic              rst_n     = 1'b0;
   logic              en        = 1'b0;
   logic [CW-1:0]     pre       = '0;
   logic [CW-1:0]     now;
   logic [NCH-1:0]    req       = '0;
   logic [NCH*CW-1:0] req_delay = '0;
   logic [NCH-1:0]    ack;
   logic [NCH-1:0]    cancel    = '0;
   logic [NCH-1:0]    busy;
   logic [NCH-1:0]    fire;
   logic [NCH-1:0]    irq_clr   = '0;
   logic [NCH-1:0]    pending;
   logic              irq;
`ifdef TMR_SCHED_PERIODIC_EN
   logic [NCH-1:0]    req_periodic = '0;
`endif

   tmr_alarm_sched #(.NCH(NCH), .CW(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .pre       (pre),
      .now       (now),
      .req       (req),
      .req_delay (req_delay),
      .ack       (ack),
      .cancel    (cancel),
      .busy      (busy),
      .fire      (fire),
      .irq_clr   (irq_clr),
      .pending   (pending),
      .irq       (irq)
`ifdef TMR_SCHED_PERIODIC_EN
      ,
      .req_periodic (req_periodic)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   typedef struct {
      int             cyc;
      logic [NCH-1:0] busy;
      logic [NCH-1:0] pend;
      logic           irq;
      logic [CW-1:0]  now;
   } status_t;

   typedef struct {
      int             cyc;
      logic [NCH-1:0] vec;
   } ev_t;

   status_t st_q[$];
   ev_t     ack_q[$];
   ev_t     fire_q[$];

   // Requester-side intent, applied to the DUT at the start of each modelled cycle.
   bit             want[NCH];
   int             dly[NCH];
   bit             per[NCH];
   bit             b_en  = 1'b0;
   int             b_pre = 0;
   bit             rnd_on = 1'b0;
   logic [NCH-1:0] x_cancel = '0;
   logic [NCH-1:0] x_clr    = '0;

   // Reference model: ticks still to wait per channel (0 = idle).
   int m_div, m_now, m_next;
   int m_left[NCH];
   int m_period[NCH];
   bit m_isper[NCH];
   bit m_pend[NCH];
   bit m_fire[NCH];

   task automatic reset_model();
      m_div = 0; m_now = 0; m_next = 0;
      for (int i = 0; i < NCH; i++) begin
         m_left[i] = 0; m_period[i] = 0; m_isper[i] = 0; m_pend[i] = 0; m_fire[i] = 0;
      end
   endtask

   task automatic model_cycle(output logic [NCH-1:0] acked);
      status_t        s;
      ev_t            e;
      logic [NCH-1:0] fv;
      int             g;
      bit             tick;
      bit             fired;
      fv = '0;
      s.cyc = cyc;
      for (int i = 0; i < NCH; i++) begin
         s.busy[i] = (m_left[i] != 0);
         s.pend[i] = m_pend[i];
         fv[i]     = m_fire[i];
      end
      s.irq = (s.pend != '0);
      s.now = CW'(m_now);
      st_q.push_back(s);

      g = -1;
      for (int k = 0; k < NCH; k++) begin
         int c;
         c = (m_next + k) % NCH;
         if (g < 0 && req[c] && m_left[c] == 0) g = c;
      end
      acked = '0;
      if (g >= 0) acked[g] = 1'b1;
      e.cyc = cyc;
      if (acked != '0) begin e.vec = acked; ack_q.push_back(e); end
      if (fv != '0)    begin e.vec = fv;    fire_q.push_back(e); end

      tick = en && (m_div >= int'(pre));
      if (tick) begin
         m_div = 0;
         m_now = (m_now + 1) % (MAXV + 1);
      end else if (en) begin
         m_div++;
      end

      for (int i = 0; i < NCH; i++) begin
         fired = 0;
         if (i == g) begin
            m_left[i]   = (dly[i] < 1) ? 1 : dly[i];
            m_period[i] = m_left[i];
            m_isper[i]  = per[i];
         end else if (m_left[i] != 0) begin
            if (cancel[i]) begin
               m_left[i] = 0;
            end else if (tick) begin
               m_left[i]--;
               if (m_left[i] == 0) begin
                  fired = 1;
                  if (m_isper[i]) m_left[i] = m_period[i];
               end
            end
         end
         m_pend[i] = fired || (m_pend[i] && !irq_clr[i]);
         m_fire[i] = fired;
      end
      if (g >= 0) m_next = (g + 1) % NCH;
   endtask

   task automatic randomize_intent();
      for (int i = 0; i < NCH; i++) begin
         if (!want[i] && $urandom_range(0, 7) == 0) begin
            want[i] = 1;
            dly[i]  = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 7));
`ifdef TMR_SCHED_PERIODIC_EN
            per[i]  = ($urandom_range(0, 3) == 0);
`endif
         end
         x_cancel[i] = ($urandom_range(0, 19) == 0);
         x_clr[i]    = ($urandom_range(0, 5) == 0);
      end
      b_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) b_pre = int'($urandom_range(0, 3));
   endtask

   task automatic apply_and_model(input int trig_ch, input bit trig_cancel, output bit hit);
      logic [NCH-1:0] acked;
      hit = 0;
      if (rnd_on) randomize_intent();
      en  = b_en;
      pre = CW'(b_pre);
      for (int i = 0; i < NCH; i++) begin
         req[i] = want[i];
         req_delay[i*CW +: CW] = CW'(dly[i]);
`ifdef TMR_SCHED_PERIODIC_EN
         req_periodic[i] = per[i];
`endif
      end
      cancel  = x_cancel;
      irq_clr = x_clr;
      x_cancel = '0;
      x_clr    = '0;
      if (trig_ch >= 0 && m_left[trig_ch] == 1 && en && m_div >= int'(pre)) begin
         hit = 1;
         if (trig_cancel) cancel[trig_ch] = 1'b1;
         else             irq_clr[trig_ch] = 1'b1;
      end
      model_cycle(acked);
      for (int i = 0; i < NCH; i++) if (acked[i]) want[i] = 0;
   endtask

   task automatic step(input int n);
      bit h;
      repeat (n) begin
         @(posedge clk); #1;
         apply_and_model(-1, 1'b0, h);
      end
   endtask

   task automatic run_to_expiry(input int ch, input bit do_cancel);
      bit h;
      int n;
      h = 0; n = 0;
      while (!h && n < 100) begin
         @(posedge clk); #1;
         apply_and_model(ch, do_cancel, h);
         n++;
      end
      chk("expiry_trigger_reached", 32'(h), 32'd1);
   endtask

   task automatic arm(input int ch, input int d, input bit p);
      want[ch] = 1; dly[ch] = d; per[ch] = p;
   endtask

   task automatic check_reset_outputs();
      chk("rst_now", 32'(now), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fire", 32'(fire), 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
   endtask

   task automatic do_reset();
      bit h;
      @(posedge clk); #1;
      rst_n = 1'b0;
      req = '0; cancel = '0; irq_clr = '0;
      for (int i = 0; i < NCH; i++) begin want[i] = 0; per[i] = 0; end
      #1;
      check_reset_outputs();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      reset_model();
      apply_and_model(-1, 1'b0, h);
   endtask

   // Monitor: one status compare per modelled cycle, event compares whenever
   // the DUT raises ack/fire or the model expected it to.
   always @(negedge clk) begin : monitor
      status_t        s;
      ev_t            e;
      logic [NCH-1:0] ev;
      if (rst_n) begin
         if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
            s = st_q.pop_front();
            chk("busy", 32'(busy), 32'(s.busy));
            chk("pending", 32'(pending), 32'(s.pend));
            chk("irq", 32'(irq), 32'(s.irq));
            chk("now", 32'(now), 32'(s.now));
         end
         ev = '0;
         if (ack_q.size() > 0 && ack_q[0].cyc <= cyc) begin e = ack_q.pop_front(); ev = e.vec; end
         if (ack != '0 || ev != '0) begin
            chk("ack", 32'(ack), 32'(ev));
            $display("cyc=%0d ack=%b expected=%b", cyc, ack, ev);
         end
         ev = '0;
         if (fire_q.size() > 0 && fire_q[0].cyc <= cyc) begin e = fire_q.pop_front(); ev = e.vec; end
         if (fire != '0 || ev != '0) begin
            chk("fire", 32'(fire), 32'(ev));
            $display("cyc=%0d fire=%b expected=%b", cyc, fire, ev);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bit h;
      int n;
      for (int i = 0; i < NCH; i++) begin want[i] = 0; dly[i] = 0; per[i] = 0; end
      reset_model();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      rst_n = 1'b1;
      apply_and_model(-1, 1'b0, h);

      // Single alarm, tick every cycle.
      b_en = 1; b_pre = 0;
      arm(0, 5, 0); step(10);

      // Prescaled tick, then lower the prescale mid-count.
      b_pre = 3;
      arm(1, 2, 0); step(12);
      arm(1, 6, 0); step(5);
      b_pre = 0; step(8);

      // Simultaneous requests from pointer 0, then from pointer 2.
      do_reset();
      for (int i = 0; i < NCH; i++) arm(i, 20, 0);
      step(30);
      do_reset();
      arm(1, 1, 0); step(4);
      for (int i = 0; i < NCH; i++) arm(i, 3, 0);
      step(15);

      // Cancel on the expiry tick; zero delay.
      arm(2, 3, 0); run_to_expiry(2, 1'b1); step(5);
      arm(0, 0, 0); step(4);

      // irq_clr colliding with a new expiry, then a plain clear.
      arm(1, 1, 0); step(4);
      arm(1, 2, 0); run_to_expiry(1, 1'b0); step(3);
      x_clr = '1; step(3);

      // Reset while counting.
      arm(3, 10, 0); step(4);
      do_reset();
      b_en = 1; b_pre = 0; step(15);

`ifdef TMR_SCHED_PERIODIC_EN
      arm(3, 4, 1); step(30);
      x_cancel[3] = 1'b1; step(10);
`endif

      // Drive the timebase to all-ones and across the wrap.
      b_en = 1; b_pre = 0; n = 0;
      while (m_now != MAXV && n < 1200) begin step(1); n++; end
      chk("now_reached_max", 32'(m_now), 32'(MAXV));
      step(4);

      rnd_on = 1'b1;
      step(3000);
      rnd_on = 1'b0;
      step(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
